// File: rtl/pll_seq_pkg.sv
// Shared types, default timing constants and width helpers for the PLL reset sequencer.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABILIZE = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } state_e;

  localparam int DEF_RST_PULSE_CYC    = 16;
  localparam int DEF_LOCK_STABLE_CYC  = 1024;
  localparam int DEF_LOCK_TIMEOUT_CYC = 50000;
  localparam int DEF_MAX_RETRY        = 3;

  // One shared cycle counter covers the longest of the three dwell times.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m + 1);
  endfunction

  // Retry counter must hold 0..MAX_RETRY and is never narrower than one bit.
  function automatic int retry_width(input int max_retry);
    return (max_retry < 1) ? 1 : $clog2(max_retry + 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous status bit.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  // Next values: shift the raw input through two stages.
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Synchroniser stages, cleared by the block reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// Brings up the pixel-clock PLL: pulses its reset, waits for stable lock,
// retries failed locks, re-sequences on lock loss and latches a fault.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter  int RST_PULSE_CYC    = DEF_RST_PULSE_CYC,
  parameter  int LOCK_STABLE_CYC  = DEF_LOCK_STABLE_CYC,
  parameter  int LOCK_TIMEOUT_CYC = DEF_LOCK_TIMEOUT_CYC,
  parameter  int MAX_RETRY        = DEF_MAX_RETRY,
  localparam int RW               = retry_width(MAX_RETRY)
) (
  input  logic          refclk,
  input  logic          rst,
  input  logic          locked_in,
  input  logic          recal_req,
  output logic          pll_rst,
  output logic          sys_rst,
  output logic          ready,
  output logic          fault,
  output logic [RW-1:0] retry_cnt
);

  localparam int CW = cnt_width(RST_PULSE_CYC, LOCK_STABLE_CYC, LOCK_TIMEOUT_CYC);

  // A state's dwell ends on the edge where cnt holds N-1, giving exactly N cycles.
  localparam logic [CW-1:0] RST_LAST = CW'(RST_PULSE_CYC - 1);
  localparam logic [CW-1:0] STB_LAST = CW'(LOCK_STABLE_CYC - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [RW-1:0]   retry_q, retry_d;
  logic            pll_rst_q, pll_rst_d;
  logic            sys_rst_q, sys_rst_d;
  logic            ready_q, ready_d;
  logic            fault_q, fault_d;
  logic            locked_s;

  sync_2ff u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (locked_in),
    .q   (locked_s)
  );

  // Next-state, counter, retry and output decode (outputs follow the next state).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    retry_d = retry_q;

    case (state_q)
      RESET_PLL: begin
        if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        // Lock wins over a coincident timeout.
        if (locked_s) begin
          state_d = STABILIZE;
        end else if (cnt_q == TO_LAST) begin
          if (retry_q == RETRY_MAX) begin
            state_d = FAULT;
          end else begin
            retry_d = retry_q + 1'b1;
            state_d = RESET_PLL;
          end
        end
      end
      STABILIZE: begin
        // A dropout restarts the lock wait without re-pulsing the PLL.
        if (!locked_s)             state_d = WAIT_LOCK;
        else if (cnt_q == STB_LAST) state_d = RUN;
      end
      RUN: begin
        cnt_d = cnt_q;
        if (!locked_s || recal_req) begin
          state_d = RESET_PLL;
          retry_d = '0;
        end
      end
      FAULT: begin
        cnt_d = cnt_q;
        if (recal_req) begin
          state_d = RESET_PLL;
          retry_d = '0;
        end
      end
      default: begin
        state_d = RESET_PLL;
        retry_d = '0;
      end
    endcase

    if (state_d != state_q) cnt_d = '0;

    pll_rst_d = (state_d == RESET_PLL) || (state_d == FAULT);
    sys_rst_d = (state_d != RUN);
    ready_d   = (state_d == RUN);
    fault_d   = (state_d == FAULT);
  end

  // State, counter and registered outputs.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q   <= RESET_PLL;
      cnt_q     <= '0;
      retry_q   <= '0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      pll_rst_q <= pll_rst_d;
      sys_rst_q <= sys_rst_d;
      ready_q   <= ready_d;
      fault_q   <= fault_d;
    end
  end

  assign pll_rst   = pll_rst_q;
  assign sys_rst   = sys_rst_q;
  assign ready     = ready_q;
  assign fault     = fault_q;
  assign retry_cnt = retry_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: a time-based reference model predicts every
// output change; a monitor matches DUT output changes against that queue.
module tb_pll_reset_sequencer;

  localparam int RP = 4, LS = 8, TO = 32, MR = 2;
  localparam int HMAX = 16384;

  logic       refclk = 1'b0;
  logic       rst = 1'b1, locked_in = 1'b0, recal_req = 1'b0;
  logic       pll_rst, sys_rst, ready, fault;
  logic [1:0] retry_cnt;

  pll_reset_sequencer #(
    .RST_PULSE_CYC(RP), .LOCK_STABLE_CYC(LS),
    .LOCK_TIMEOUT_CYC(TO), .MAX_RETRY(MR)
  ) dut (
    .refclk(refclk), .rst(rst), .locked_in(locked_in), .recal_req(recal_req),
    .pll_rst(pll_rst), .sys_rst(sys_rst), .ready(ready), .fault(fault),
    .retry_cnt(retry_cnt)
  );

  always #5 refclk = ~refclk;

  typedef struct {int cyc; logic [5:0] val;} ev_t;
  ev_t q[$];

  int errors = 0, checks = 0;
  int cyc = 0;          // index of the next rising edge
  int base = 0;         // edge 0 of the current bring-up
  int ready_rise = -1, sys_rise = -1, fault_rise = -1, pll_rises = 0;

  // ---------------- reference model (absolute-time phases) ----------------
  localparam int M_RST = 0, M_WAIT = 1, M_STAB = 2, M_RUN = 3, M_FLT = 4;
  bit lk_hist [HMAX];

  initial begin
    int ph, start, retries, rst_edge, k, nph;
    bit ls;
    logic [5:0] expv, prev_exp;
    ph = M_RST; start = 0; retries = 0; rst_edge = 0; prev_exp = 'x;
    forever begin
      @(posedge refclk);
      k = cyc;
      lk_hist[k % HMAX] = locked_in;
      if (rst) begin
        ph = M_RST; start = k; retries = 0; rst_edge = k;
      end else begin
        // lock seen by the controller is locked_in from two edges earlier
        ls  = (k - 2 > rst_edge) ? lk_hist[(k - 2) % HMAX] : 1'b0;
        nph = ph;
        case (ph)
          M_RST:  if (k - start == RP) nph = M_WAIT;
          M_WAIT: if (ls) nph = M_STAB;
                  else if (k - start == TO) begin
                    if (retries == MR) nph = M_FLT;
                    else begin retries++; nph = M_RST; end
                  end
          M_STAB: if (!ls) nph = M_WAIT;
                  else if (k - start == LS) nph = M_RUN;
          M_RUN:  if (!ls || recal_req) begin nph = M_RST; retries = 0; end
          default: if (recal_req) begin nph = M_RST; retries = 0; end
        endcase
        if (nph != ph) start = k;
        ph = nph;
      end
      expv = {ph == M_RST || ph == M_FLT, ph != M_RUN, ph == M_RUN, ph == M_FLT, 2'(retries)};
      if (expv !== prev_exp) q.push_back('{k, expv});
      prev_exp = expv;
      cyc++;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [5:0] cur, prev_dut;
    ev_t e;
    prev_dut = 'x;
    forever begin
      @(negedge refclk);
      cur = {pll_rst, sys_rst, ready, fault, retry_cnt};
      if (q.size() > 0 && q[0].cyc < cyc - 1) begin
        e = q.pop_front();
        checks++; errors++;
        $display("FAIL missing_event edge=%0d exp=%b got=%b", e.cyc, e.val, cur);
      end
      if (cur !== prev_dut) begin
        if (cur[3] === 1'b1 && prev_dut[3] !== 1'b1) ready_rise = cyc - 1;
        if (cur[4] === 1'b1 && prev_dut[4] === 1'b0) sys_rise = cyc - 1;
        if (cur[2] === 1'b1 && prev_dut[2] !== 1'b1) fault_rise = cyc - 1;
        if (cur[5] === 1'b1 && prev_dut[5] === 1'b0) pll_rises++;
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change edge=%0d got=%b", cyc - 1, cur);
        end else begin
          e = q.pop_front();
          if (e.cyc != cyc - 1 || e.val !== cur) begin
            errors++;
            $display("FAIL output_event got edge=%0d val=%b exp edge=%0d val=%b",
                     cyc - 1, cur, e.cyc, e.val);
          end
        end
      end
      prev_dut = cur;
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic go_to(input int rel);
    while (cyc < base + rel) @(negedge refclk);
  endtask

  // one-edge reset pulse, then check reset values and set edge 0
  task automatic do_reset();
    @(negedge refclk);
    rst = 1'b1;
    @(negedge refclk);
    chk("reset_values", int'({pll_rst, sys_rst, ready, fault, retry_cnt}), int'(6'b110000));
    rst = 1'b0;
    base = cyc;
  endtask

  task automatic wait_ready(input int limit, input string name);
    int n;
    n = 0;
    while (ready !== 1'b1 && n < limit) begin @(negedge refclk); n++; end
    chk(name, int'(ready === 1'b1), 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int d, hold, pr0;
    repeat (3) @(negedge refclk);

    // normal bring-up
    do_reset();
    go_to(10); locked_in = 1'b1;
    go_to(30);
    chk("bringup_ready_edge", ready_rise - base, 20);
    chk("bringup_sys_rst", int'(sys_rst), 0);

    // lock loss in RUN
    go_to(40);
    locked_in = 1'b0; d = cyc;
    hold = $urandom_range(1, 6);
    repeat (hold) @(negedge refclk);
    locked_in = 1'b1;
    go_to(40 + hold + 10);
    chk("lockloss_sys_rst_edge", sys_rise - d, 2);
    wait_ready(60, "lockloss_reready");
    chk("lockloss_retry", int'(retry_cnt), 0);

    // one-cycle glitch five cycles into STABILIZE
    do_reset();
    locked_in = 1'b0;
    go_to(10); locked_in = 1'b1;
    go_to(12); pr0 = pll_rises;
    go_to(15); locked_in = 1'b0;
    go_to(16); locked_in = 1'b1;
    go_to(40);
    chk("glitch_ready_edge", ready_rise - base, 26);
    chk("glitch_no_pll_pulse", pll_rises - pr0, 0);
    chk("glitch_retry", int'(retry_cnt), 0);

    // never locks: three pulses, then FAULT
    do_reset();
    locked_in = 1'b0;
    pr0 = pll_rises;
    go_to(115);
    chk("nolock_fault_edge", fault_rise - base, 107);
    chk("nolock_pll_rises", pll_rises - pr0, 3);
    chk("nolock_fault_outs", int'({pll_rst, sys_rst, ready, fault, retry_cnt}), int'(6'b110110));

    // recalibration from FAULT
    locked_in = 1'b1;
    repeat (5) @(negedge refclk);
    recal_req = 1'b1;
    @(negedge refclk);
    recal_req = 1'b0;
    chk("recal_fault_clear", int'(fault), 0);
    chk("recal_retry_clear", int'(retry_cnt), 0);
    wait_ready(60, "recal_ready");

    // reset mid-STABILIZE
    do_reset();
    go_to(10); locked_in = 1'b1;
    go_to(15);
    do_reset();
    go_to(30);
    chk("midreset_ready_edge", ready_rise - base, 12);

    // randomized lock activity with occasional recalibration
    for (int i = 0; i < 25; i++) begin
      locked_in = 1'($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 4) == 0) begin
        recal_req = 1'b1;
        @(negedge refclk);
        recal_req = 1'b0;
      end
      repeat ($urandom_range(1, 45)) @(negedge refclk);
    end

    // recover and drain
    locked_in = 1'b1;
    repeat (3) @(negedge refclk);
    recal_req = 1'b1;
    @(negedge refclk);
    recal_req = 1'b0;
    repeat (60) @(negedge refclk);
    chk("final_ready", int'(ready), 1);
    chk("queue_drained", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
